// File: rtl/freq_counter_pkg.sv
// Shared definitions for the multi-channel frequency counter.
//   state_t    : measurement FSM states (idle, gate window open, latch results)
//   SEG_ZERO   : seven-segment glyph for "0" (gfedcba, active-high)
//   hex_to_seg : hex nibble to seven-segment glyph (gfedcba, active-high)
package freq_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam logic [6:0] SEG_ZERO = 7'h3F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/freq_channel.sv
// One measurement channel: 2-FF synchroniser, rising-edge detector and a
// saturating edge counter with a window-overflow flag.
//   clk, reset_n : clock, asynchronous active-low reset
//   signal       : asynchronous input being measured
//   count_en     : count detected rising edges this cycle
//   clear        : window boundary; counter restarts (at 1 if an edge is
//                  counted in the same cycle, else 0) and overflow clears
//   count        : edge count of the current window (saturates at all-ones)
//   overflow     : set when an edge arrives while the count is saturated
module freq_channel
    import freq_counter_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               signal,
    input  logic               count_en,
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic sync_1;
    logic sync_2;
    logic sync_prev;
    logic rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= signal;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            // An edge seen on the boundary cycle opens the next window at 1.
            count    <= (count_en && rise) ? COUNT_W'(1) : '0;
            overflow <= 1'b0;
        end else if (count_en && rise) begin
            if (count == COUNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                count <= count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/frequency_counter_multi.sv
// Multi-channel gated frequency counter with seven-segment readout.
// A gate window of period_reg clk cycles is followed by one latch cycle that
// captures every channel's edge count and overflow flag.
//   clk, reset_n : clock, asynchronous active-low reset
//   signal       : CHANNELS asynchronous measured inputs
//   period_load  : capture 'period' into the pending gate length
//   period       : gate length in clk cycles
//   mode_oneshot : 1 = one window per start pulse, 0 = continuous
//   start        : begin a one-shot window from idle
//   chan_sel     : channel shown on result and display (out of range -> 0)
//   result       : latched count of the selected channel
//   result_valid : one-cycle pulse as new results become visible
//   overflow     : per-channel saturation flags of the last window
//   busy         : high while a window or latch is in progress
//   segments     : active-high gfedcba glyph of the scanned digit
//   digit        : one-hot active-high digit enable
module frequency_counter_multi
    import freq_counter_pkg::*;
#(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned COUNT_W        = 16,
    parameter int unsigned PERIOD_W       = 16,
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_W         = 10,
    parameter int unsigned DEFAULT_PERIOD = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] signal,
    input  logic                period_load,
    input  logic [PERIOD_W-1:0] period,
    input  logic                mode_oneshot,
    input  logic                start,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] chan_sel,
    output logic [COUNT_W-1:0]  result,
    output logic                result_valid,
    output logic [CHANNELS-1:0] overflow,
    output logic                busy,
    output logic [6:0]          segments,
    output logic [DIGITS-1:0]   digit
);

    localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(DEFAULT_PERIOD);

    state_t              state;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] period_pend;
    logic [PERIOD_W-1:0] next_period;
    logic                continue_run;
    logic                count_en;
    logic                clear;

    logic [COUNT_W-1:0]  chan_count [CHANNELS];
    logic [CHANNELS-1:0] chan_ovf;
    logic [COUNT_W-1:0]  results    [CHANNELS];

    logic [SCAN_W-1:0]   scan;
    logic [DIG_W-1:0]    digit_idx;
    logic [4*DIGITS-1:0] display_word;
    logic [3:0]          nibble;

    // A load in the same cycle as a window start takes effect immediately.
    assign next_period  = period_load ? period : period_pend;
    assign continue_run = !mode_oneshot && (next_period != '0);

    // Counting spans the gate cycles plus the latch cycle when another window
    // follows, so an edge on the boundary lands in the next window.
    assign count_en = (state == ST_GATE) || ((state == ST_LATCH) && continue_run);
    assign clear    = (state != ST_GATE);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        freq_channel #(
            .COUNT_W(COUNT_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .signal  (signal[g]),
            .count_en(count_en),
            .clear   (clear),
            .count   (chan_count[g]),
            .overflow(chan_ovf[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            timer        <= '0;
            period_reg   <= PERIOD_RST;
            period_pend  <= PERIOD_RST;
            results      <= '{default: '0};
            overflow     <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (period_load) begin
                period_pend <= period;
            end
            case (state)
                ST_IDLE: begin
                    period_reg <= next_period;
                    if ((next_period != '0) && (!mode_oneshot || start)) begin
                        state <= ST_GATE;
                        timer <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_GATE: begin
                    if (timer == period_reg - PERIOD_W'(1)) begin
                        state <= ST_LATCH;
                    end else begin
                        timer <= timer + PERIOD_W'(1);
                    end
                end
                ST_LATCH: begin
                    results      <= chan_count;
                    overflow     <= chan_ovf;
                    result_valid <= 1'b1;
                    timer        <= '0;
                    if (continue_run) begin
                        state      <= ST_GATE;
                        period_reg <= next_period;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan      <= '0;
            digit_idx <= '0;
        end else begin
            scan <= scan + SCAN_W'(1);
            if (scan == '1) begin
                if (digit_idx == DIG_W'(DIGITS - 1)) begin
                    digit_idx <= '0;
                end else begin
                    digit_idx <= digit_idx + DIG_W'(1);
                end
            end
        end
    end

    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (chan_sel == SEL_W'(i)) begin
                result = results[i];
            end
        end
    end

    always_comb begin
        display_word = '0;
        display_word[COUNT_W-1:0] = result;
        nibble = '0;
        digit  = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (digit_idx == DIG_W'(k)) begin
                nibble   = display_word[4*k +: 4];
                digit[k] = 1'b1;
            end
        end
        segments = hex_to_seg(nibble);
    end

endmodule

// File: tb/tb_frequency_counter_multi.sv
// Self-checking bench for frequency_counter_multi. A window-level reference
// model attributes each input rising edge to a measurement window from its
// sample time and the gate/latch schedule, then predicts every output.
module tb_frequency_counter_multi;

    localparam int CH   = 3;
    localparam int CW   = 5;
    localparam int PW   = 16;
    localparam int DG   = 4;
    localparam int SW   = 3;
    localparam int DEFP = 100;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] signal;
    logic          period_load;
    logic [PW-1:0] period;
    logic          mode_oneshot;
    logic          start;
    logic [1:0]    chan_sel;
    logic [CW-1:0] result;
    logic          result_valid;
    logic [CH-1:0] overflow;
    logic          busy;
    logic [6:0]    segments;
    logic [DG-1:0] digit;

    always #5 clk = ~clk;

    frequency_counter_multi #(
        .CHANNELS      (CH),
        .COUNT_W       (CW),
        .PERIOD_W      (PW),
        .DIGITS        (DG),
        .SCAN_W        (SW),
        .DEFAULT_PERIOD(DEFP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .signal      (signal),
        .period_load (period_load),
        .period      (period),
        .mode_oneshot(mode_oneshot),
        .start       (start),
        .chan_sel    (chan_sel),
        .result      (result),
        .result_valid(result_valid),
        .overflow    (overflow),
        .busy        (busy),
        .segments    (segments),
        .digit       (digit)
    );

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: window schedule plus per-window edge tallies.
    int m_active;
    int m_pos;      // 0..m_P-1 gate cycles, m_P = latch cycle
    int m_P;
    int m_pend;
    int m_valid;
    int n_edges;
    int cnt [CH];
    int lat [CH];
    bit lat_ovf [CH];
    bit q1 [CH];
    bit q2 [CH];
    bit q3 [CH];

    // Stimulus controls.
    bit sq_en, sat_en, rnd_en, dir_en;
    int gc = 0;

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_P = DEFP; m_pend = DEFP; m_valid = 0; n_edges = 0;
        for (int c = 0; c < CH; c++) begin
            cnt[c] = 0; lat[c] = 0; lat_ovf[c] = 0; q1[c] = 0; q2[c] = 0; q3[c] = 0;
        end
    endtask

    task automatic model_edge();
        bit r [CH];
        int new_pend;
        for (int c = 0; c < CH; c++) begin
            r[c]  = q2[c] & ~q3[c];
            q3[c] = q2[c];
            q2[c] = q1[c];
            q1[c] = signal[c];
        end
        new_pend = period_load ? int'(period) : m_pend;
        m_valid  = 0;
        n_edges++;
        if (m_active == 0) begin
            if (new_pend != 0 && (!mode_oneshot || start)) begin
                m_active = 1; m_pos = 0; m_P = new_pend;
                for (int c = 0; c < CH; c++) cnt[c] = 0;
            end
        end else if (m_pos < m_P) begin
            for (int c = 0; c < CH; c++) if (r[c]) cnt[c]++;
            m_pos++;
        end else begin
            for (int c = 0; c < CH; c++) begin
                lat[c]     = (cnt[c] > CMAX) ? CMAX : cnt[c];
                lat_ovf[c] = (cnt[c] > CMAX);
            end
            m_valid = 1;
            if (!mode_oneshot && new_pend != 0) begin
                m_pos = 0; m_P = new_pend;
                for (int c = 0; c < CH; c++) cnt[c] = r[c] ? 1 : 0;
            end else begin
                m_active = 0;
            end
        end
        m_pend = new_pend;
    endtask

    task automatic compare();
        int sel, exp_res, idx, nib;
        logic [CH-1:0] eo;
        sel     = int'(chan_sel);
        exp_res = (sel < CH) ? lat[sel] : 0;
        for (int c = 0; c < CH; c++) eo[c] = lat_ovf[c];
        idx = (n_edges / 8) % DG;
        nib = (exp_res >> (4 * idx)) & 15;
        check_eq("result_valid", result_valid, m_valid);
        check_eq("busy", busy, m_active);
        check_eq("result", result, exp_res);
        check_eq("overflow", overflow, eo);
        check_eq("digit", digit, 64'(1) << idx);
        check_eq("segments", segments, glyph[nib]);
    endtask

    task automatic drive_signals();
        int ahead;
        logic [CH-1:0] v;
        ahead = (m_pos + 2) % (m_P + 1);
        v = '0;
        if (dir_en)     v[0] = (m_active != 0) && (ahead == m_P - 1);
        else if (sq_en) v[0] = ((gc / 5) % 2) != 0;
        if (sat_en)     v[1] = ~signal[1];
        if (dir_en)     v[2] = (m_active != 0) && (ahead == m_P);
        else if (rnd_en) v[2] = ($urandom_range(0, 2) == 0) ? ~signal[2] : signal[2];
        signal = v;
        gc++;
    endtask

    task automatic step();
        drive_signals();
        chan_sel = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        model_edge();
        compare();
        period_load = 1'b0;
        start       = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int hold);
        reset_n = 1'b0;
        #2;
        check_eq("rst_valid", result_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_digit", digit, 1);
        check_eq("rst_segments", segments, 7'h3F);
        repeat (hold) @(posedge clk);
        #3;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int bc, vc, first;
        reset_n = 1'b0; signal = '0; period_load = 1'b0; period = '0;
        mode_oneshot = 1'b0; start = 1'b0; chan_sel = '0;
        sq_en = 0; sat_en = 0; rnd_en = 0; dir_en = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset(2);

        // Continuous windows of 100: square wave, saturating channel, random.
        sq_en = 1; sat_en = 1; rnd_en = 1;
        run(210);
        sat_en = 0;
        run(220);

        // Shorter period loaded mid-window applies from the next window.
        run(37);
        period = 16'd20; period_load = 1'b1;
        step();
        run(200);

        // Edges placed on the final gate cycle and on the latch cycle.
        sq_en = 0; rnd_en = 0; dir_en = 1;
        run(110);

        // One-shot: finish current window, then a single 50-cycle window.
        dir_en = 0; sq_en = 1; rnd_en = 1;
        mode_oneshot = 1'b1;
        run(30);
        period = 16'd50; period_load = 1'b1;
        step();
        run(5);
        start = 1'b1;
        bc = 0; vc = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (busy) bc++;
            if (result_valid) vc++;
        end
        check_eq("oneshot_busy_len", bc, 51);
        check_eq("oneshot_valid_cnt", vc, 1);
        run(40);
        start = 1'b1;
        run(60);

        // Reset in the middle of a continuous window.
        mode_oneshot = 1'b0;
        run(80);
        do_reset(3);
        first = -1;
        for (int i = 1; i <= 300 && first < 0; i++) begin
            step();
            if (result_valid) first = i;
        end
        check_eq("first_valid_after_reset", first, DEFP + 2);
        run(120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
